bus_xfer_sequencer: RTL and testbench

//  Initiator side of the register-latch bus: turns one transfer request (src, dst)

---
 rtl/bus_xfer_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_sequencer.sv
// Register-latch bus initiator: turns one (src, dst) transfer request into registered oe/latch/setvalue strobes.
// Optional one-entry request buffer enabled by defining BUSSEQ_QUEUE_EN.
module bus_xfer_sequencer #(
    parameter int NSRC   = 8,
    parameter int NDST   = 8,
    parameter int SW     = 3,
    parameter int DW     = 3,
    parameter int SETTLE = 1,
    parameter int HOLD   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic [SW-1:0]   src,
    input  logic [DW-1:0]   dst,
    input  logic            set4000,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [NSRC-1:0] oe,
    output logic [NDST-1:0] latch,
    output logic            setvalue
);

    localparam int MAXC = (SETTLE > HOLD) ? SETTLE : HOLD;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   src_q, src_d;
    logic [DW-1:0]   dst_q, dst_d;
    logic            set_q, set_d;
    logic [NSRC-1:0] oe_q, oe_d;
    logic [NDST-1:0] latch_q, latch_d;
    logic            setvalue_q, setvalue_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            accept_s;
`ifdef BUSSEQ_QUEUE_EN
    logic [SW-1:0]   bsrc_q, bsrc_d;
    logic [DW-1:0]   bdst_q, bdst_d;
    logic            bset_q, bset_d;
    logic            bvld_q, bvld_d;
    logic            take_req_s;
`endif

    // Out-of-range indices decode to all-zero, so nothing drives or latches.
    function automatic logic [NSRC-1:0] dec_src(input logic [SW-1:0] idx);
        dec_src = '0;
        for (int i = 0; i < NSRC; i++) begin
            dec_src[i] = (int'(idx) == i);
        end
    endfunction

    function automatic logic [NDST-1:0] dec_dst(input logic [DW-1:0] idx);
        dec_dst = '0;
        for (int i = 0; i < NDST; i++) begin
            dec_dst[i] = (int'(idx) == i);
        end
    endfunction

    // Next-state, transfer capture and strobe decode (outputs decoded from the next state).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        dst_d    = dst_q;
        set_d    = set_q;
        accept_s = req & ready_q;
`ifdef BUSSEQ_QUEUE_EN
        bsrc_d     = bsrc_q;
        bdst_d     = bdst_q;
        bset_d     = bset_q;
        bvld_d     = bvld_q;
        take_req_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_GAP: begin
`ifdef BUSSEQ_QUEUE_EN
                if (bvld_q) begin
                    src_d   = bsrc_q;
                    dst_d   = bdst_q;
                    set_d   = bset_q;
                    bvld_d  = 1'b0;
                    state_d = ST_DRIVE;
                    cnt_d   = CW'(SETTLE - 1);
                end else if (accept_s) begin
                    take_req_s = 1'b1;
                    src_d      = src;
                    dst_d      = dst;
                    set_d      = set4000;
                    state_d    = ST_DRIVE;
                    cnt_d      = CW'(SETTLE - 1);
                end else begin
                    state_d = ST_IDLE;
                end
`else
                if (accept_s) begin
                    src_d   = src;
                    dst_d   = dst;
                    set_d   = set4000;
                    state_d = ST_DRIVE;
                    cnt_d   = CW'(SETTLE - 1);
                end else begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_DRIVE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_STROBE;
                    cnt_d   = CW'(HOLD - 1);
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_STROBE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_GAP;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase

`ifdef BUSSEQ_QUEUE_EN
        // A request not launched directly waits in the buffer; launches always drain the buffer first.
        if (accept_s && !take_req_s) begin
            bvld_d = 1'b1;
            bsrc_d = src;
            bdst_d = dst;
            bset_d = set4000;
        end else begin
            bvld_d = bvld_d;
        end
        ready_d = ~bvld_d;
`else
        ready_d = (state_d == ST_IDLE);
`endif

        if ((state_d == ST_DRIVE) || (state_d == ST_STROBE)) begin
            oe_d       = set_d ? {NSRC{1'b0}} : dec_src(src_d);
            setvalue_d = set_d;
        end else begin
            oe_d       = {NSRC{1'b0}};
            setvalue_d = 1'b0;
        end
        latch_d = (state_d == ST_STROBE) ? dec_dst(dst_d) : {NDST{1'b0}};
        done_d  = (state_d == ST_GAP);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and registered strobes; reset aborts any transfer immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            src_q      <= {SW{1'b0}};
            dst_q      <= {DW{1'b0}};
            set_q      <= 1'b0;
            oe_q       <= {NSRC{1'b0}};
            latch_q    <= {NDST{1'b0}};
            setvalue_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            set_q      <= set_d;
            oe_q       <= oe_d;
            latch_q    <= latch_d;
            setvalue_q <= setvalue_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

`ifdef BUSSEQ_QUEUE_EN
    // One-entry request buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            bsrc_q <= {SW{1'b0}};
            bdst_q <= {DW{1'b0}};
            bset_q <= 1'b0;
            bvld_q <= 1'b0;
        end else begin
            bsrc_q <= bsrc_d;
            bdst_q <= bdst_d;
            bset_q <= bset_d;
            bvld_q <= bvld_d;
        end
    end
`endif

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign oe       = oe_q;
    assign latch    = latch_q;
    assign setvalue = setvalue_q;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed bench for bus_xfer_sequencer: default timing instance (a_*) and SETTLE=3/HOLD=2 instance (b_*).
// Expectations follow the buffered variant when BUSSEQ_QUEUE_EN is defined.
module tb_bus_xfer_sequencer;

`ifdef BUSSEQ_QUEUE_EN
    localparam logic QR = 1'b1;
`else
    localparam logic QR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_req, a_set, a_ready, a_busy, a_done, a_setvalue;
    logic [3:0] a_src, a_dst;
    logic [7:0] a_oe, a_latch;
    logic       b_req, b_set, b_ready, b_busy, b_done, b_setvalue;
    logic [3:0] b_src, b_dst;
    logic [7:0] b_oe, b_latch;

    int cmp_cnt = 0;
    int err_cnt = 0;

    bus_xfer_sequencer #(.NSRC(8), .NDST(8), .SW(4), .DW(4), .SETTLE(1), .HOLD(1)) dut_a (
        .clk(clk), .reset(reset), .req(a_req), .src(a_src), .dst(a_dst), .set4000(a_set),
        .ready(a_ready), .busy(a_busy), .done(a_done), .oe(a_oe), .latch(a_latch),
        .setvalue(a_setvalue)
    );

    bus_xfer_sequencer #(.NSRC(8), .NDST(8), .SW(4), .DW(4), .SETTLE(3), .HOLD(2)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .src(b_src), .dst(b_dst), .set4000(b_set),
        .ready(b_ready), .busy(b_busy), .done(b_done), .oe(b_oe), .latch(b_latch),
        .setvalue(b_setvalue)
    );

    // Bus/latch model for instance a: sources hold distinct values, latches capture on rising edge.
    function automatic logic [11:0] sval(input int i);
        return 12'(i * 37 + 5);
    endfunction

    logic [11:0] bus_s;
    logic [11:0] lreg [8] = '{default: 12'h000};
    logic [7:0]  latch_prev = 8'h00;

    always_comb begin
        bus_s = 12'h000;
        if (a_setvalue) begin
            bus_s = 12'o4000;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (a_oe[i]) bus_s = bus_s | sval(i);
            end
        end
    end

    always @(posedge clk) begin
        latch_prev <= a_latch;
        for (int i = 0; i < 8; i++) begin
            if (a_latch[i] && !latch_prev[i]) lreg[i] <= bus_s;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [7:0] oe_e, input logic [7:0] latch_e,
                         input logic sv_e, input logic done_e, input logic busy_e, input logic ready_e);
        chk({tag, ".oe"},       32'(a_oe),       32'(oe_e));
        chk({tag, ".latch"},    32'(a_latch),    32'(latch_e));
        chk({tag, ".setvalue"}, 32'(a_setvalue), 32'(sv_e));
        chk({tag, ".done"},     32'(a_done),     32'(done_e));
        chk({tag, ".busy"},     32'(a_busy),     32'(busy_e));
        chk({tag, ".ready"},    32'(a_ready),    32'(ready_e));
    endtask

    initial begin
        int s2;
        int drop;
        reset = 1'b1;
        a_req = 1'b0; a_src = 4'd0; a_dst = 4'd0; a_set = 1'b0;
        b_req = 1'b0; b_src = 4'd0; b_dst = 4'd0; b_set = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_a("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst.b_ready", 32'(b_ready), 32'd1);
        reset = 1'b0;

        // Basic transfer src=2 -> dst=5
        a_req = 1'b1; a_src = 4'd2; a_dst = 4'd5;
        @(negedge clk); a_req = 1'b0;
        chk_a("t1c1", 8'h04, 8'h00, 1'b0, 1'b0, 1'b1, QR);
        @(negedge clk); chk_a("t1c2", 8'h04, 8'h20, 1'b0, 1'b0, 1'b1, QR);
        @(negedge clk); chk_a("t1c3", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, QR);
        @(negedge clk); chk_a("t1c4", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1.lreg5", 32'(lreg[5]), 32'(sval(2)));

        // Constant 4000 (octal) into dst=0
        a_req = 1'b1; a_set = 1'b1; a_src = 4'd3; a_dst = 4'd0;
        @(negedge clk); a_req = 1'b0; a_set = 1'b0;
        chk_a("t2c1", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, QR);
        @(negedge clk); chk_a("t2c2", 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, QR);
        @(negedge clk); chk_a("t2c3", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, QR);
        @(negedge clk); chk("t2.lreg0", 32'(lreg[0]), 32'o4000);

        // Out-of-range source: no oe, latch still pulses, bus reads 0
        a_req = 1'b1; a_src = 4'd9; a_dst = 4'd1;
        @(negedge clk); a_req = 1'b0;
        chk_a("t5c1", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, QR);
        @(negedge clk); chk_a("t5c2", 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, QR);
        @(negedge clk); chk_a("t5c3", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, QR);
        @(negedge clk); chk_a("t5c4", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5.lreg1", 32'(lreg[1]), 32'd0);

        // Out-of-range destination: no latch, done still occurs
        a_req = 1'b1; a_src = 4'd1; a_dst = 4'd12;
        @(negedge clk); a_req = 1'b0;
        chk_a("tdc1", 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, QR);
        @(negedge clk); chk_a("tdc2", 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, QR);
        @(negedge clk); chk_a("tdc3", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, QR);
        @(negedge clk);

`ifndef BUSSEQ_QUEUE_EN
        // Request presented while busy is ignored
        a_req = 1'b1; a_src = 4'd4; a_dst = 4'd6;
        @(negedge clk); a_src = 4'd1; a_dst = 4'd3;
        chk_a("tbc1", 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); chk_a("tbc2", 8'h10, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); a_req = 1'b0;
        chk_a("tbc3", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); chk_a("tbc4", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk_a("tbc5", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Reset during STROBE aborts the transfer
        a_req = 1'b1; a_src = 4'd2; a_dst = 4'd7;
        @(negedge clk); a_req = 1'b0;
        @(negedge clk); chk_a("t4c2", 8'h04, 8'h80, 1'b0, 1'b0, 1'b1, QR);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk_a("t4c3", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk_a("t4c4", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk_a("t4c5", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // SETTLE=3 HOLD=2 with request held high (back-to-back)
`ifdef BUSSEQ_QUEUE_EN
        s2 = 7; drop = 2;
`else
        s2 = 8; drop = 8;
`endif
        b_req = 1'b1; b_src = 4'd1; b_dst = 4'd6;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == drop) b_req = 1'b0;
            chk($sformatf("t3c%0d.oe", c), 32'(b_oe),
                (((c >= 1) && (c <= 5)) || ((c >= s2) && (c <= s2 + 4))) ? 32'h02 : 32'h00);
            chk($sformatf("t3c%0d.latch", c), 32'(b_latch),
                ((c == 4) || (c == 5) || (c == s2 + 3) || (c == s2 + 4)) ? 32'h40 : 32'h00);
            chk($sformatf("t3c%0d.done", c), 32'(b_done),
                ((c == 6) || (c == s2 + 5)) ? 32'd1 : 32'd0);
        end

`ifdef BUSSEQ_QUEUE_EN
        // Two requests on consecutive cycles through the buffer
        a_req = 1'b1; a_src = 4'd2; a_dst = 4'd5;
        @(negedge clk); a_src = 4'd3; a_dst = 4'd4;
        chk_a("t6c1", 8'h04, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); a_req = 1'b0;
        chk_a("t6c2", 8'h04, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); chk_a("t6c3", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); chk_a("t6c4", 8'h08, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); chk_a("t6c5", 8'h08, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); chk_a("t6c6", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk); chk("t6.lreg4", 32'(lreg[4]), 32'(sval(3)));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
